// File: rtl/mem_wb_elastic_if.sv
// MEM/WB elastic stage bundle: upstream handshake, head outputs,
// writeback strobe, EX bypass port and stall counter.
interface mem_wb_elastic_if #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_wb;
    logic [DATA_W-1:0]     in_read_data;
    logic [DATA_W-1:0]     in_mem_address;
    logic [REG_ADDR_W-1:0] in_rd;

    logic                  out_valid;
    logic                  out_ready;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [DATA_W-1:0]     read_data_out;
    logic [DATA_W-1:0]     mem_address_out;
    logic [REG_ADDR_W-1:0] rd_out;
    logic [DATA_W-1:0]     wb_data;
    logic                  rf_we;

    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_rd;
    logic [DATA_W-1:0]     fwd_data;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output flush, in_valid, in_wb, in_read_data,
        output in_mem_address, in_rd, out_ready,
        input  in_ready, out_valid, mem_to_reg, reg_write,
        input  read_data_out, mem_address_out, rd_out,
        input  wb_data, rf_we, fwd_valid, fwd_rd,
        input  fwd_data, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_wb, in_read_data,
        input  in_mem_address, in_rd, out_ready,
        output in_ready, out_valid, mem_to_reg, reg_write,
        output read_data_out, mem_address_out, rd_out,
        output wb_data, rf_we, fwd_valid, fwd_rd,
        output fwd_data, stall_cnt
    );
endinterface

// File: rtl/mem_wb_elastic.sv
// MEM/WB pipeline register as a 1- or 2-entry elastic buffer with
// flush, x0 write suppression, EX bypass port and stall counter.
module mem_wb_elastic #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter bit SKID_EN    = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_wb_elastic_if.slave   bus
);

    typedef struct packed {
        logic [1:0]            wb;
        logic [DATA_W-1:0]     rdata;
        logic [DATA_W-1:0]     addr;
        logic [REG_ADDR_W-1:0] rd;
    } entry_t;

    entry_t           h_q, h_d;
    entry_t           s_q, s_d;
    logic             h_valid_q, h_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    entry_t in_e;
    logic   in_ready;
    logic   accept;
    logic   retire;
    logic   reg_write;
    logic [DATA_W-1:0] wb_data;

    assign in_e = '{
        wb:    bus.in_wb,
        rdata: bus.in_read_data,
        addr:  bus.in_mem_address,
        rd:    bus.in_rd
    };

    // Skid mode derives ready purely from a flop, cutting the
    // out_ready -> in_ready path.
    assign in_ready = SKID_EN ? ~s_valid_q
                              : (~h_valid_q | bus.out_ready);
    assign accept   = bus.in_valid & in_ready;
    assign retire   = h_valid_q & bus.out_ready;

    always_comb begin
        h_d       = h_q;
        s_d       = s_q;
        h_valid_d = h_valid_q;
        s_valid_d = s_valid_q;
        stall_d   = stall_q;

        if (SKID_EN) begin
            if (retire) begin
                if (s_valid_q) begin
                    h_d       = s_q;
                    s_valid_d = 1'b0;
                end else if (accept) begin
                    h_d = in_e;
                end else begin
                    h_valid_d = 1'b0;
                end
            end else if (accept) begin
                if (!h_valid_q) begin
                    h_valid_d = 1'b1;
                    h_d       = in_e;
                end else begin
                    s_valid_d = 1'b1;
                    s_d       = in_e;
                end
            end
        end else begin
            if (accept) begin
                h_valid_d = 1'b1;
                h_d       = in_e;
            end else if (retire) begin
                h_valid_d = 1'b0;
            end
        end

        // Flush drops everything; payload is left untouched.
        if (bus.flush) begin
            h_valid_d = 1'b0;
            s_valid_d = 1'b0;
            h_d       = h_q;
            s_d       = s_q;
        end

        if (h_valid_q && !bus.out_ready
                && stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q       <= '0;
            s_q       <= '0;
            h_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            h_q       <= h_d;
            s_q       <= s_d;
            h_valid_q <= h_valid_d;
            s_valid_q <= s_valid_d;
            stall_q   <= stall_d;
        end
    end

    assign reg_write = h_q.wb[1] & h_valid_q
                     & (h_q.rd != '0);
    assign wb_data   = h_q.wb[0] ? h_q.rdata : h_q.addr;

    assign bus.in_ready        = in_ready;
    assign bus.out_valid       = h_valid_q;
    assign bus.mem_to_reg      = h_q.wb[0];
    assign bus.reg_write       = reg_write;
    assign bus.read_data_out   = h_q.rdata;
    assign bus.mem_address_out = h_q.addr;
    assign bus.rd_out          = h_q.rd;
    assign bus.wb_data         = wb_data;
    assign bus.rf_we           = retire & reg_write;
    assign bus.fwd_valid       = reg_write;
    assign bus.fwd_rd          = h_q.rd;
    assign bus.fwd_data        = wb_data;
    assign bus.stall_cnt       = stall_q;

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Bench for mem_wb_elastic: skid (CNT_W=16) and single-entry
// (CNT_W=4) instances against a queue-based reference model.
module tb_mem_wb_elastic;

    typedef struct packed {
        logic [1:0]  wb;
        logic [63:0] rdata;
        logic [63:0] addr;
        logic [4:0]  rd;
    } ent_t;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    ent_t        qa[$];
    ent_t        qb[$];
    int unsigned sa;
    int unsigned sb;

    mem_wb_elastic_if #(.CNT_W(16)) bus_a ();
    mem_wb_elastic_if #(.CNT_W(4))  bus_b ();

    mem_wb_elastic #(.SKID_EN(1'b1), .CNT_W(16)) u_skid (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a.slave)
    );

    mem_wb_elastic #(.SKID_EN(1'b0), .CNT_W(4)) u_flow (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [1:0] wb,
                         input logic [63:0] rdat,
                         input logic [63:0] addr,
                         input logic [4:0] rd,
                         input logic ordy, input logic fl);
        bus_a.in_valid       = v;
        bus_a.in_wb          = wb;
        bus_a.in_read_data   = rdat;
        bus_a.in_mem_address = addr;
        bus_a.in_rd          = rd;
        bus_a.out_ready      = ordy;
        bus_a.flush          = fl;
        bus_b.in_valid       = v;
        bus_b.in_wb          = wb;
        bus_b.in_read_data   = rdat;
        bus_b.in_mem_address = addr;
        bus_b.in_rd          = rd;
        bus_b.out_ready      = ordy;
        bus_b.flush          = fl;
        #1;
    endtask

    // Clock edge plus reference-model update from the pre-edge inputs.
    task automatic tick();
        ent_t e;
        bit   ordy, ra, rb, ca, cb;
        @(posedge clk);
        e    = {bus_a.in_wb, bus_a.in_read_data,
                bus_a.in_mem_address, bus_a.in_rd};
        ordy = bus_a.out_ready;
        if (rst) begin
            qa.delete();
            qb.delete();
            sa = 0;
            sb = 0;
        end else begin
            ra = qa.size() < 2;
            rb = (qb.size() == 0) || ordy;
            ca = bus_a.in_valid && ra;
            cb = bus_a.in_valid && rb;
            if (qa.size() > 0 && !ordy && sa < 65535) sa++;
            if (qb.size() > 0 && !ordy && sb < 15) sb++;
            if (bus_a.flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (qa.size() > 0 && ordy) void'(qa.pop_front());
                if (qb.size() > 0 && ordy) void'(qb.pop_front());
                if (ca) qa.push_back(e);
                if (cb) qb.push_back(e);
            end
        end
        #1;
    endtask

    function automatic logic [4:0] exp_ctl(input bit skid,
                                           input int n,
                                           input ent_t h,
                                           input logic ordy);
        logic v, rdy, rw;
        v   = n > 0;
        rdy = skid ? (n < 2) : (n == 0 || ordy);
        rw  = v && h.wb[1] && (h.rd != 5'd0);
        return {v, rdy, rw, rw && ordy, rw};
    endfunction

    function automatic logic [266:0] exp_pay(input ent_t h);
        logic [63:0] wd;
        wd = h.wb[0] ? h.rdata : h.addr;
        return {h.rd, h.rd, h.wb[0], h.rdata, h.addr, wd, wd};
    endfunction

    task automatic test_reset();
        logic [266:0] zero_pay;
        zero_pay = '0;
        rst = 1'b1;
        drive(1'b0, 2'b00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({bus_a.out_valid, bus_a.in_ready, bus_a.reg_write,
             bus_a.rf_we, bus_a.fwd_valid} !== 5'b01000) begin
            $display("FAIL reset_ctl_a got %b want 01000",
                {bus_a.out_valid, bus_a.in_ready, bus_a.reg_write,
                 bus_a.rf_we, bus_a.fwd_valid});
        end else pass_cnt++;
        total_cnt++;
        if ({bus_b.out_valid, bus_b.in_ready, bus_b.reg_write,
             bus_b.rf_we, bus_b.fwd_valid} !== 5'b01000) begin
            $display("FAIL reset_ctl_b got %b want 01000",
                {bus_b.out_valid, bus_b.in_ready, bus_b.reg_write,
                 bus_b.rf_we, bus_b.fwd_valid});
        end else pass_cnt++;
        total_cnt++;
        if ({bus_a.rd_out, bus_a.fwd_rd, bus_a.mem_to_reg,
             bus_a.read_data_out, bus_a.mem_address_out,
             bus_a.wb_data, bus_a.fwd_data} !== zero_pay) begin
            $display("FAIL reset_payload_a got nonzero want 0");
        end else pass_cnt++;
        total_cnt++;
        if (bus_a.stall_cnt !== 16'd0 || bus_b.stall_cnt !== 4'd0) begin
            $display("FAIL reset_stall got %0d/%0d want 0/0",
                bus_a.stall_cnt, bus_b.stall_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'b10, 64'($urandom), 64'(16 * i),
                  5'(i), 1'b1, 1'b0);
            tick();
            total_cnt++;
            if (bus_a.out_valid !== 1'b1 || bus_a.rd_out !== 5'(i)
                    || bus_a.rf_we !== 1'b1
                    || bus_a.wb_data !== 64'(16 * i)) begin
                $display("FAIL stream_a[%0d] got v=%b rd=%0d we=%b wd=%h want 1 %0d 1 %h",
                    i, bus_a.out_valid, bus_a.rd_out, bus_a.rf_we,
                    bus_a.wb_data, i, 16 * i);
            end else pass_cnt++;
            total_cnt++;
            if (bus_b.out_valid !== 1'b1 || bus_b.rd_out !== 5'(i)
                    || bus_b.rf_we !== 1'b1
                    || bus_b.wb_data !== 64'(16 * i)) begin
                $display("FAIL stream_b[%0d] got v=%b rd=%0d we=%b wd=%h want 1 %0d 1 %h",
                    i, bus_b.out_valid, bus_b.rd_out, bus_b.rf_we,
                    bus_b.wb_data, i, 16 * i);
            end else pass_cnt++;
        end
        drive(1'b0, 2'b00, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
        tick();
        total_cnt++;
        if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
            $display("FAIL stream_drain got %b%b want 00",
                bus_a.out_valid, bus_b.out_valid);
        end else pass_cnt++;
    endtask

    task automatic test_skid_stall();
        drive(1'b1, 2'b10, 64'd0, 64'h50, 5'd5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'b10, 64'd0, 64'h60, 5'd6, 1'b0, 1'b0);
        tick();
        total_cnt++;
        if (bus_a.in_ready !== 1'b0 || bus_a.rd_out !== 5'd5) begin
            $display("FAIL skid_full got rdy=%b rd=%0d want 0 5",
                bus_a.in_ready, bus_a.rd_out);
        end else pass_cnt++;
        drive(1'b1, 2'b10, 64'd0, 64'h70, 5'd7, 1'b0, 1'b0);
        tick();
        total_cnt++;
        if (bus_a.in_ready !== 1'b0 || bus_a.rd_out !== 5'd5
                || bus_a.mem_address_out !== 64'h50) begin
            $display("FAIL skid_hold got rdy=%b rd=%0d want 0 5",
                bus_a.in_ready, bus_a.rd_out);
        end else pass_cnt++;
        total_cnt++;
        if (bus_a.stall_cnt !== 16'd2) begin
            $display("FAIL skid_stall_cnt got %0d want 2",
                bus_a.stall_cnt);
        end else pass_cnt++;
        drive(1'b1, 2'b10, 64'd0, 64'h70, 5'd7, 1'b1, 1'b0);
        total_cnt++;
        if (bus_a.rf_we !== 1'b1 || bus_a.rd_out !== 5'd5) begin
            $display("FAIL skid_ret5 got we=%b rd=%0d want 1 5",
                bus_a.rf_we, bus_a.rd_out);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (bus_a.rd_out !== 5'd6 || bus_a.in_ready !== 1'b1) begin
            $display("FAIL skid_ret6 got rd=%0d rdy=%b want 6 1",
                bus_a.rd_out, bus_a.in_ready);
        end else pass_cnt++;
        tick();
        drive(1'b0, 2'b00, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
        total_cnt++;
        if (bus_a.rd_out !== 5'd7 || bus_a.wb_data !== 64'h70) begin
            $display("FAIL skid_ret7 got rd=%0d wd=%h want 7 70",
                bus_a.rd_out, bus_a.wb_data);
        end else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (bus_a.out_valid !== 1'b0 || bus_a.stall_cnt !== 16'd2) begin
            $display("FAIL skid_empty got v=%b cnt=%0d want 0 2",
                bus_a.out_valid, bus_a.stall_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_forward();
        drive(1'b1, 2'b11, 64'hDEAD_BEEF, 64'h100, 5'd9, 1'b1, 1'b0);
        tick();
        total_cnt++;
        if (bus_a.wb_data !== 64'hDEAD_BEEF || bus_a.fwd_valid !== 1'b1
                || bus_a.fwd_rd !== 5'd9
                || bus_a.fwd_data !== 64'hDEAD_BEEF
                || bus_a.rf_we !== 1'b1) begin
            $display("FAIL fwd_a got wd=%h fv=%b frd=%0d want deadbeef 1 9",
                bus_a.wb_data, bus_a.fwd_valid, bus_a.fwd_rd);
        end else pass_cnt++;
        total_cnt++;
        if (bus_b.wb_data !== 64'hDEAD_BEEF || bus_b.fwd_valid !== 1'b1
                || bus_b.fwd_rd !== 5'd9) begin
            $display("FAIL fwd_b got wd=%h fv=%b frd=%0d want deadbeef 1 9",
                bus_b.wb_data, bus_b.fwd_valid, bus_b.fwd_rd);
        end else pass_cnt++;
        drive(1'b1, 2'b11, 64'hDEAD_BEEF, 64'h100, 5'd0, 1'b1, 1'b0);
        tick();
        total_cnt++;
        if ({bus_a.reg_write, bus_a.rf_we, bus_a.fwd_valid} !== 3'b000
                || bus_a.out_valid !== 1'b1
                || bus_a.wb_data !== 64'hDEAD_BEEF) begin
            $display("FAIL x0_a got rw/we/fv=%b v=%b wd=%h want 000 1 deadbeef",
                {bus_a.reg_write, bus_a.rf_we, bus_a.fwd_valid},
                bus_a.out_valid, bus_a.wb_data);
        end else pass_cnt++;
        total_cnt++;
        if ({bus_b.reg_write, bus_b.rf_we, bus_b.fwd_valid} !== 3'b000) begin
            $display("FAIL x0_b got %b want 000",
                {bus_b.reg_write, bus_b.rf_we, bus_b.fwd_valid});
        end else pass_cnt++;
        drive(1'b0, 2'b00, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 2'b10, 64'd0, 64'h110, 5'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 2'b10, 64'd0, 64'h120, 5'h12, 1'b0, 1'b0);
        tick();
        total_cnt++;
        if (bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b1) begin
            $display("FAIL flush_pre got rdy=%b v=%b want 0 1",
                bus_a.in_ready, bus_a.out_valid);
        end else pass_cnt++;
        drive(1'b1, 2'b10, 64'd0, 64'h130, 5'h13, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'b00, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
        total_cnt++;
        if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1
                || bus_b.out_valid !== 1'b0) begin
            $display("FAIL flush_post got va=%b rdy=%b vb=%b want 0 1 0",
                bus_a.out_valid, bus_a.in_ready, bus_b.out_valid);
        end else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
                $display("FAIL flush_ghost[%0d] got %b%b want 00",
                    i, bus_a.out_valid, bus_b.out_valid);
            end else pass_cnt++;
        end
    endtask

    task automatic test_saturate();
        drive(1'b1, 2'b10, 64'd0, 64'h1, 5'd1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'b00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        total_cnt++;
        if (bus_b.stall_cnt !== 4'd15) begin
            $display("FAIL sat_cnt got %0d want 15", bus_b.stall_cnt);
        end else pass_cnt++;
        total_cnt++;
        if (bus_a.stall_cnt !== 16'(sa)) begin
            $display("FAIL sat_cnt_a got %0d want %0d",
                bus_a.stall_cnt, sa);
        end else pass_cnt++;
        drive(1'b0, 2'b00, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'b00, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
        total_cnt++;
        if (bus_b.stall_cnt !== 4'd15 || bus_b.out_valid !== 1'b0) begin
            $display("FAIL sat_flush got cnt=%0d v=%b want 15 0",
                bus_b.stall_cnt, bus_b.out_valid);
        end else pass_cnt++;
    endtask

    task automatic test_random();
        ent_t         ha, hb;
        logic [4:0]   oc, ec;
        logic [266:0] op, ep;
        logic         ordy;
        logic [4:0]   rd;
        for (int c = 0; c < 400; c++) begin
            ordy = ($urandom_range(0, 3) != 0);
            rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            drive(1'($urandom), 2'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, rd, ordy,
                  $urandom_range(0, 15) == 0);
            ha = (qa.size() > 0) ? qa[0] : ent_t'(0);
            hb = (qb.size() > 0) ? qb[0] : ent_t'(0);
            oc = {bus_a.out_valid, bus_a.in_ready, bus_a.reg_write,
                  bus_a.rf_we, bus_a.fwd_valid};
            ec = exp_ctl(1'b1, qa.size(), ha, ordy);
            total_cnt++;
            if (oc !== ec) begin
                $display("FAIL rand_ctl_a[%0d] got %b want %b", c, oc, ec);
            end else pass_cnt++;
            oc = {bus_b.out_valid, bus_b.in_ready, bus_b.reg_write,
                  bus_b.rf_we, bus_b.fwd_valid};
            ec = exp_ctl(1'b0, qb.size(), hb, ordy);
            total_cnt++;
            if (oc !== ec) begin
                $display("FAIL rand_ctl_b[%0d] got %b want %b", c, oc, ec);
            end else pass_cnt++;
            if (qa.size() > 0) begin
                op = {bus_a.rd_out, bus_a.fwd_rd, bus_a.mem_to_reg,
                      bus_a.read_data_out, bus_a.mem_address_out,
                      bus_a.wb_data, bus_a.fwd_data};
                ep = exp_pay(ha);
                total_cnt++;
                if (op !== ep) begin
                    $display("FAIL rand_pay_a[%0d] got %h want %h",
                        c, op, ep);
                end else pass_cnt++;
            end
            if (qb.size() > 0) begin
                op = {bus_b.rd_out, bus_b.fwd_rd, bus_b.mem_to_reg,
                      bus_b.read_data_out, bus_b.mem_address_out,
                      bus_b.wb_data, bus_b.fwd_data};
                ep = exp_pay(hb);
                total_cnt++;
                if (op !== ep) begin
                    $display("FAIL rand_pay_b[%0d] got %h want %h",
                        c, op, ep);
                end else pass_cnt++;
            end
            total_cnt++;
            if (bus_a.stall_cnt !== 16'(sa)
                    || bus_b.stall_cnt !== 4'(sb)) begin
                $display("FAIL rand_stall[%0d] got %0d/%0d want %0d/%0d",
                    c, bus_a.stall_cnt, bus_b.stall_cnt, sa, sb);
            end else pass_cnt++;
            tick();
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        sa        = 0;
        sb        = 0;
        rst       = 1'b1;
        test_reset();
        test_stream();
        test_skid_stall();
        test_forward();
        test_flush();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
